// File: rtl/phj_release_pkg.sv
// Shared types and helpers for the ordered release sequencer.
package phj_release_pkg;

  localparam int SERIAL_W = 32;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Unit that owns a serial; num_units is a power of two so this folds to a bit slice.
  function automatic logic [SERIAL_W-1:0] owner_idx(input logic [SERIAL_W-1:0] serial,
                                                    input int unsigned num_units);
    return serial % num_units;
  endfunction

endpackage

// File: rtl/sync_result_fifo.sv
// Single-clock result FIFO; pop_data shows the head entry (zero while empty).
module sync_result_fifo #(
  parameter int DATA_SIZE  = 128,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] pop_data,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  logic [DATA_SIZE-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign pop_data  = empty ? {DATA_SIZE{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= do_push_s ? wr_ptr_r + 1'b1 : wr_ptr_r;
      rd_ptr_r <= do_pop_s  ? rd_ptr_r + 1'b1 : rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array: data only, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/ordered_release_sequencer.sv
// Retires serials in order across NUM_UNITS store-and-release buffers and merges
// their outputs into one valid/ready stream. Optional watchdog: RELEASE_WATCHDOG_EN.
module ordered_release_sequencer
  import phj_release_pkg::*;
#(
  parameter int DATA_SIZE  = 128,
  parameter int NUM_UNITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [SERIAL_W-1:0]            next,
  output logic [NUM_UNITS-1:0]           release_data,
  output logic [NUM_UNITS-1:0]           skip_data,
  input  logic [NUM_UNITS-1:0]           unit_next_in_storage,
  input  logic [NUM_UNITS-1:0]           unit_next_joined,
  input  logic [NUM_UNITS-1:0]           unit_out_valid,
  input  logic [NUM_UNITS*DATA_SIZE-1:0] unit_out_data,
  input  logic [NUM_UNITS-1:0]           unit_last_processed,
  output logic [DATA_SIZE-1:0]           m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           protocol_err
`ifdef RELEASE_WATCHDOG_EN
  ,
  output logic [SERIAL_W-1:0]            stall_serial
`endif
);

  localparam int OWN_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if ((NUM_UNITS < 1) || ((NUM_UNITS & (NUM_UNITS - 1)) != 0)) begin : g_bad_num_units
    $error("NUM_UNITS must be a power of two");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  seq_state_t             state_r;
  seq_state_t             state_nx_s;
  logic [SERIAL_W-1:0]    next_r;
  logic                   inflight_r;
  logic                   err_r;
  logic [OWN_W-1:0]       own_s;
  logic [NUM_UNITS-1:0]   own_oh_s;
  logic [DATA_SIZE-1:0]   sel_data_s;
  logic                   credit_ok_s;
  logic                   do_release_s;
  logic                   do_skip_s;
  logic                   do_flush_s;
  logic                   advance_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   err_evt_s;
  logic                   wdog_hit_s;
  logic [DATA_SIZE-1:0]   fifo_head_s;
  logic [CNT_W-1:0]       fifo_count_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  assign own_s    = OWN_W'(owner_idx(next_r, NUM_UNITS));
  assign own_oh_s = {{(NUM_UNITS-1){1'b0}}, 1'b1} << own_s;
  assign next     = next_r;

  // The in-flight credit reserves a slot for the beat that arrives one cycle after release.
  assign credit_ok_s = ({1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r})
                       < (CNT_W+1)'(FIFO_DEPTH);

  assign advance_s = do_skip_s | (state_r == WAIT);
  assign push_s    = (state_r == WAIT) & unit_out_valid[own_s] & ~fifo_full_s;
  assign pop_s     = m_valid & m_ready & ~fifo_empty_s;

  // Any response outside the WAIT slot or from a non-owner is a protocol error, as is silence in WAIT.
  assign err_evt_s = (state_r == WAIT)
                     ? (~unit_out_valid[own_s] | (|(unit_out_valid & ~own_oh_s)))
                     : (|unit_out_valid);

  // Pick the owning unit's data lane.
  always_comb begin
    sel_data_s = {DATA_SIZE{1'b0}};
    for (int i = 0; i < NUM_UNITS; i++) begin
      sel_data_s |= (own_s == OWN_W'(i)) ? unit_out_data[i*DATA_SIZE +: DATA_SIZE]
                                         : {DATA_SIZE{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ISSUE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state and action decode.
  always_comb begin
    state_nx_s   = state_r;
    do_release_s = 1'b0;
    do_skip_s    = 1'b0;
    do_flush_s   = 1'b0;
    case (state_r)
      ISSUE: begin
        if (unit_next_in_storage[own_s] & unit_next_joined[own_s] & credit_ok_s) begin
          do_release_s = 1'b1;
          state_nx_s   = WAIT;
        end else if (unit_next_in_storage[own_s] & ~unit_next_joined[own_s]) begin
          do_skip_s    = 1'b1;
          state_nx_s   = ISSUE;
        end else if ((&unit_last_processed) & fifo_empty_s) begin
          do_flush_s   = 1'b1;
          state_nx_s   = FLUSH;
        end else begin
          state_nx_s   = ISSUE;
        end
      end
      WAIT:    state_nx_s = ISSUE;
      FLUSH:   state_nx_s = m_ready ? DONE : FLUSH;
      DONE:    state_nx_s = DONE;
      default: state_nx_s = ISSUE;
    endcase
  end

  // FSM outputs: unit pulses and the merged result stream.
  always_comb begin
    release_data = {NUM_UNITS{1'b0}};
    skip_data    = {NUM_UNITS{1'b0}};
    m_valid      = 1'b0;
    m_last       = 1'b0;
    m_data       = {DATA_SIZE{1'b0}};
    case (state_r)
      ISSUE: begin
        release_data = do_release_s ? own_oh_s : {NUM_UNITS{1'b0}};
        skip_data    = do_skip_s ? own_oh_s : {NUM_UNITS{1'b0}};
        m_valid      = ~fifo_empty_s;
        m_data       = fifo_head_s;
      end
      WAIT: begin
        m_valid = ~fifo_empty_s;
        m_data  = fifo_head_s;
      end
      FLUSH: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = {DATA_SIZE{1'b0}};
      end
      DONE: begin
        m_valid = 1'b0;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  // Serial counter, in-flight credit and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_r     <= {SERIAL_W{1'b0}};
      inflight_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      next_r     <= advance_s ? next_r + 1'b1 : next_r;
      if (do_release_s) begin
        inflight_r <= 1'b1;
      end else if (state_r == WAIT) begin
        inflight_r <= 1'b0;
      end else begin
        inflight_r <= inflight_r;
      end
      err_r      <= err_r | err_evt_s | wdog_hit_s;
    end
  end

  assign protocol_err = err_r;

`ifdef RELEASE_WATCHDOG_EN
  logic [SERIAL_W-1:0] wdog_cnt_r;
  logic [SERIAL_W-1:0] stall_serial_r;
  logic                issue_act_s;

  assign issue_act_s = do_release_s | do_skip_s | do_flush_s;
  assign wdog_hit_s  = (state_r == ISSUE) & ~issue_act_s
                       & (wdog_cnt_r == SERIAL_W'(TIMEOUT - 1));

  // Idle-cycle counter in ISSUE; saturates at the limit so the hit fires once per stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_r     <= {SERIAL_W{1'b0}};
      stall_serial_r <= {SERIAL_W{1'b0}};
    end else begin
      if ((state_r == ISSUE) & issue_act_s) begin
        wdog_cnt_r <= {SERIAL_W{1'b0}};
      end else if ((state_r == ISSUE) & (wdog_cnt_r < SERIAL_W'(TIMEOUT))) begin
        wdog_cnt_r <= wdog_cnt_r + 1'b1;
      end else begin
        wdog_cnt_r <= wdog_cnt_r;
      end
      stall_serial_r <= wdog_hit_s ? next_r : stall_serial_r;
    end
  end

  assign stall_serial = stall_serial_r;
`else
  assign wdog_hit_s = 1'b0;
`endif

  sync_result_fifo #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (sel_data_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_ordered_release_sequencer.sv
// Scoreboard bench: a behavioural unit model answers releases, a monitor checks the result stream.
module tb_ordered_release_sequencer;

  localparam int DW = 128;
  localparam int NU = 8;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       next;
  logic [NU-1:0]     release_data;
  logic [NU-1:0]     skip_data;
  logic [NU-1:0]     unit_next_in_storage;
  logic [NU-1:0]     unit_next_joined;
  logic [NU-1:0]     unit_out_valid;
  logic [NU*DW-1:0]  unit_out_data;
  logic [NU-1:0]     unit_last_processed;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              protocol_err;

  ordered_release_sequencer #(
    .DATA_SIZE  (DW),
    .NUM_UNITS  (NU),
    .FIFO_DEPTH (FD),
    .TIMEOUT    (1024)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .next                 (next),
    .release_data         (release_data),
    .skip_data            (skip_data),
    .unit_next_in_storage (unit_next_in_storage),
    .unit_next_joined     (unit_next_joined),
    .unit_out_valid       (unit_out_valid),
    .unit_out_data        (unit_out_data),
    .unit_last_processed  (unit_last_processed),
    .m_data               (m_data),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_last               (m_last),
    .protocol_err         (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] nxt;
    logic [7:0]  rel;
    logic [7:0]  skp;
  } ev_t;

  exp_t sb[$];
  ev_t  ev[$];
  bit   avail  [64];
  bit   joined [64];
  bit   noresp [64];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input int lo, input int hi);
    for (int s = lo; s <= hi; s++) begin
      avail[s]  = 1'b1;
      joined[s] = 1'b1;
    end
  endtask

  task automatic expect_beat(input logic [127:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 64; i++) begin
      avail[i]  = 1'b0;
      joined[i] = 1'b0;
      noresp[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    clear_tables();
    tick();
    tick();
    reset = 1'b0;
    ev.delete();
  endtask

  task automatic wait_next(input logic [31:0] target, input int budget, input string name);
    int k = 0;
    while (next != target && k < budget) begin
      tick();
      k++;
    end
    check(name, 128'(next), 128'(target));
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check(name, 128'(sb.size()), 128'd0);
  endtask

  // Behavioural units: present serial `next` from the tables, answer a release one cycle later.
  initial begin : unit_model
    logic [7:0]  rel;
    logic [31:0] ser;
    ev_t         e;
    unit_out_valid       = '0;
    unit_out_data        = '0;
    unit_next_in_storage = '0;
    unit_next_joined     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      rel = release_data;
      ser = next;
      if (!reset && (release_data != 8'h00 || skip_data != 8'h00)) begin
        e.cyc = cyc;
        e.nxt = next;
        e.rel = release_data;
        e.skp = skip_data;
        ev.push_back(e);
      end
      @(posedge clk);
      #1;
      unit_out_valid = '0;
      unit_out_data  = '0;
      if (!reset && rel != 8'h00 && !noresp[ser[5:0]]) begin
        unit_out_valid = rel;
        unit_out_data[ser[2:0]*DW +: DW] = DW'(ser) * DW'(16);
      end
      unit_next_in_storage = '0;
      unit_next_joined     = '0;
      if (avail[next[5:0]]) begin
        unit_next_in_storage[next[2:0]] = 1'b1;
        unit_next_joined[next[2:0]]     = joined[next[5:0]];
      end
    end
  end

  // Monitor: sample just before the rising edge and retire each accepted beat against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: actual data 0x%0h last %0b required no beat", m_data, m_last);
        end else begin
          e = sb.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", 128'(m_last), 128'(e.last));
        end
      end
    end
  end

  initial begin : main
    int skips;
    int k;
    reset               = 1'b1;
    m_ready             = 1'b0;
    unit_last_processed = '0;
    clear_tables();
    #2;
    check("rst_next", 128'(next), 128'd0);
    check("rst_release", 128'(release_data), 128'd0);
    check("rst_skip", 128'(skip_data), 128'd0);
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_m_last", 128'(m_last), 128'd0);
    check("rst_protocol_err", 128'(protocol_err), 128'd0);
    tick();
    tick();
    reset = 1'b0;

    // Basic in-order retirement of serials 0..7
    m_ready = 1'b1;
    for (int s = 0; s < 8; s++) expect_beat(128'(s * 16), 1'b0);
    offer(0, 7);
    wait_next(32'd8, 60, "basic_next");
    wait_drain("basic_drain");
    check("basic_rel_count", 128'(ev.size()), 128'd8);
    if (ev.size() == 8) begin
      for (int i = 0; i < 8; i++) check("basic_rel_onehot", 128'(ev[i].rel), 128'(1 << i));
    end

    // Non-joined serial 3 is skipped without a WAIT cycle
    do_reset();
    m_ready = 1'b1;
    offer(0, 5);
    joined[3] = 1'b0;
    expect_beat(128'h00, 1'b0);
    expect_beat(128'h10, 1'b0);
    expect_beat(128'h20, 1'b0);
    expect_beat(128'h40, 1'b0);
    expect_beat(128'h50, 1'b0);
    wait_next(32'd6, 60, "skip_next");
    wait_drain("skip_drain");
    skips = 0;
    foreach (ev[i]) if (ev[i].skp != 8'h00) skips++;
    check("skip_count", 128'(skips), 128'd1);
    check("skip_event_count", 128'(ev.size()), 128'd6);
    if (ev.size() == 6) begin
      check("skip_mask", 128'(ev[3].skp), 128'h08);
      check("skip_serial", 128'(ev[3].nxt), 128'd3);
      check("skip_no_release", 128'(ev[3].rel), 128'h00);
      check("after_skip_release", 128'(ev[4].rel), 128'h10);
      check("after_skip_gap", 128'(ev[4].cyc - ev[3].cyc), 128'd1);
    end

    // Backpressure: only FIFO_DEPTH releases while m_ready is low
    do_reset();
    m_ready = 1'b0;
    offer(0, 9);
    for (int s = 0; s < 10; s++) expect_beat(128'(s * 16), 1'b0);
    repeat (40) tick();
    check("bp_next_hold", 128'(next), 128'd4);
    check("bp_release_count", 128'(ev.size()), 128'd4);
    check("bp_release_idle", 128'(release_data), 128'd0);
    check("bp_m_valid", 128'(m_valid), 128'd1);
    check("bp_head", m_data, 128'h00);
    m_ready = 1'b1;
    wait_next(32'd10, 100, "bp_next_final");
    wait_drain("bp_drain");
    check("bp_release_total", 128'(ev.size()), 128'd10);

    // Missing response on serial 1
    do_reset();
    m_ready = 1'b1;
    check("miss_err_before", 128'(protocol_err), 128'd0);
    offer(0, 2);
    noresp[1] = 1'b1;
    expect_beat(128'h00, 1'b0);
    expect_beat(128'h20, 1'b0);
    wait_next(32'd3, 40, "miss_next");
    wait_drain("miss_drain");
    check("miss_err_set", 128'(protocol_err), 128'd1);
    repeat (5) tick();
    check("miss_err_sticky", 128'(protocol_err), 128'd1);

    // Asynchronous reset while in WAIT with two FIFO entries (serials 3,4 are lost)
    m_ready = 1'b0;
    offer(3, 5);
    k = 0;
    while (release_data != 8'h20 && k < 40) begin
      tick();
      k++;
    end
    check("async_pre_release", 128'(release_data), 128'h20);
    @(posedge clk);
    #2;
    check("async_pre_next", 128'(next), 128'd5);
    check("async_pre_m_valid", 128'(m_valid), 128'd1);
    check("async_pre_err", 128'(protocol_err), 128'd1);
    reset = 1'b1;
    #1;
    check("async_next", 128'(next), 128'd0);
    check("async_m_valid", 128'(m_valid), 128'd0);
    check("async_err", 128'(protocol_err), 128'd0);
    clear_tables();
    tick();
    tick();
    reset = 1'b0;
    ev.delete();

    // End of stream after five serials
    m_ready = 1'b1;
    offer(0, 4);
    for (int s = 0; s < 5; s++) expect_beat(128'(s * 16), 1'b0);
    wait_next(32'd5, 40, "eos_next");
    wait_drain("eos_data_drain");
    m_ready             = 1'b0;
    unit_last_processed = '1;
    expect_beat(128'h0, 1'b1);
    repeat (3) tick();
    check("eos_m_valid", 128'(m_valid), 128'd1);
    check("eos_m_last", 128'(m_last), 128'd1);
    check("eos_m_data", m_data, 128'h0);
    m_ready = 1'b1;
    wait_drain("eos_beat_drain");
    repeat (3) tick();
    check("done_m_valid", 128'(m_valid), 128'd0);
    check("done_m_last", 128'(m_last), 128'd0);
    check("done_next", 128'(next), 128'd5);
    check("done_err", 128'(protocol_err), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : time_limit
    #200000;
    $display("FAIL time_limit: actual still running required finished");
    $fatal(1, "simulation time limit");
  end

endmodule
